// File: rtl/adain_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adain_pkg
// Brief   : Shared constants and helpers for the AdaIN shift arbiter.
// Revision: 1.0  initial release
// ============================================================================
package adain_pkg;

  localparam int ADAIN_CNT_W   = 16;
  localparam int ADAIN_MAX_REQ = 8;

  // Never returns 0, so a single-value field still gets one bit.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scan upward from ptr, wrapping at n; the first set valid bit wins.
  function automatic logic [2:0] rr_pick(input logic [ADAIN_MAX_REQ-1:0] valid,
                                         input logic [2:0]               ptr,
                                         input int                       n);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < ADAIN_MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (i < n && !found && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adain_shift_core.sv
`default_nettype none
// ============================================================================
// Module  : adain_shift_core
// Brief   : Clamped zero-fill left barrel shifter with shifted-out-ones flag.
// Revision: 1.0  initial release
// ============================================================================
module adain_shift_core
  import adain_pkg::*;
#(
  parameter int WIDTH     = 48,
  parameter int MAX_SHIFT = 15,
  parameter int SW        = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [SW-1:0]    shift_amt,
  output logic [WIDTH-1:0] data_out,
  output logic             ovf
);

  localparam logic [SW-1:0] C_MAX_SHIFT = SW'(MAX_SHIFT);

  logic [SW-1:0]        w_amt;
  logic [2*WIDTH-1:0]   w_ext;

  assign w_amt = (shift_amt > C_MAX_SHIFT) ? C_MAX_SHIFT : shift_amt;

  // Shift a double-width copy so the bits pushed out land in the upper half.
  always_comb begin
    w_ext = {{WIDTH{1'b0}}, data_in};
    for (int k = 0; k < SW; k++) begin
      if (w_amt[k]) w_ext = w_ext << (1 << k);
    end
  end

  assign data_out = w_ext[WIDTH-1:0];
  assign ovf      = |w_ext[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: rtl/adain_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : adain_shift_arbiter
// Brief   : Round-robin sharing of one barrel shifter between NUM_REQ lanes.
// Revision: 1.0  initial release
// ============================================================================
module adain_shift_arbiter
  import adain_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 48,
  parameter  int MAX_SHIFT = 15,
  parameter  int CNT_W     = ADAIN_CNT_W,
  localparam int SW        = clog2_safe(MAX_SHIFT + 1),
  localparam int IDW       = clog2_safe(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*SW-1:0] req_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_ovf,
  output logic [CNT_W-1:0]      ovf_cnt,
  input  logic                  ovf_clr
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [SW-1:0]    r_s1_shift;
  logic [IDW-1:0]   r_s1_id;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [IDW-1:0]   r_out_id;
  logic             r_out_ovf;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic [IDW-1:0]   r_ptr;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [IDW-1:0]     w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_ovf;
  logic               w_out_hs;

  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_grant  = IDW'(rr_pick(ADAIN_MAX_REQ'(req_valid), 3'(r_ptr), NUM_REQ));
  assign w_out_hs = r_out_valid && out_ready;

  // out_ready reaches req_ready combinationally through w_s2_adv.
  always_comb begin
    w_ready = '0;
    if (!rst && w_s1_adv && (|req_valid)) w_ready[w_grant] = 1'b1;
  end

  assign w_accept  = |(req_valid & w_ready);
  assign req_ready = w_ready;

  adain_shift_core #(
    .WIDTH     (WIDTH),
    .MAX_SHIFT (MAX_SHIFT),
    .SW        (SW)
  ) u_core (
    .data_in   (r_s1_data),
    .shift_amt (r_s1_shift),
    .data_out  (w_shifted),
    .ovf       (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_shift  <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_out_ovf   <= 1'b0;
      r_ovf_cnt   <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_s2_adv) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_shifted;
          r_out_id   <= r_s1_id;
          r_out_ovf  <= w_ovf;
        end
      end
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_data  <= req_data[w_grant*WIDTH +: WIDTH];
          r_s1_shift <= req_shift[w_grant*SW +: SW];
          r_s1_id    <= w_grant;
          r_ptr      <= (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
        end
      end
      // Clear wins over a same-cycle increment.
      if (ovf_clr) begin
        r_ovf_cnt <= '0;
      end else if (w_out_hs && r_out_ovf && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_ovf   = r_out_ovf;
  assign ovf_cnt   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adain_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_adain_shift_arbiter
// Brief   : Directed and randomized self-checking bench for the shift arbiter.
// Revision: 1.0  initial release
// ============================================================================
module tb_adain_shift_arbiter;

  localparam int NR = 4, W = 48, SW = 4, IDW = 2, CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready;
  logic [NR*W-1:0]  req_data;
  logic [NR*SW-1:0] req_shift;
  logic             out_valid, out_ready, out_ovf, ovf_clr;
  logic [W-1:0]     out_data;
  logic [IDW-1:0]   out_id;
  logic [CW-1:0]    ovf_cnt;

  // Second instance with a non-power-of-two shift range.
  logic [1:0]    v2, rdy2;
  logic [2*W-1:0] data2;
  logic [7:0]    shift2;
  logic          ov2, ordy2, ovf2, clr2;
  logic [W-1:0]  od2;
  logic [0:0]    id2;
  logic [CW-1:0] cnt2;

  adain_shift_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_SHIFT(15), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_ovf(out_ovf), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr));

  adain_shift_arbiter #(.NUM_REQ(2), .WIDTH(W), .MAX_SHIFT(12), .CNT_W(CW)) u_dut12 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2),
    .req_data(data2), .req_shift(shift2), .out_valid(ov2),
    .out_ready(ordy2), .out_data(od2), .out_id(id2),
    .out_ovf(ovf2), .ovf_cnt(cnt2), .ovf_clr(clr2));

  int n_vec = 0;
  int n_err = 0;

  typedef struct { logic [W-1:0] d; int s; int id; } item_t;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input int maxs);
    int c;
    c = (s > maxs) ? maxs : s;
    return d << c;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] d, input int s, input int maxs);
    int c;
    c = (s > maxs) ? maxs : s;
    if (c == 0) return 1'b0;
    return (d >> (W - c)) != '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] d, input int s);
    req_data[i*W +: W]    = d;
    req_shift[i*SW +: SW] = SW'(s);
  endtask

  task automatic do_reset();
    req_valid = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    v2 = '0; ordy2 = 1'b1; clr2 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_data = '0; req_shift = '0; data2 = '0; shift2 = '0;
    out_ready = 1'b1; ovf_clr = 1'b0; v2 = '0; ordy2 = 1'b1; clr2 = 1'b0;
    rst = 1'b1; req_valid = '1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    n_vec++; if (out_id !== '0 || out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_id_ovf got %0d/%b exp 0/0", out_id, out_ovf); end
    n_vec++; if (ovf_cnt !== '0) begin n_err++; $display("FAIL reset_ovf_cnt got %0d exp 0", ovf_cnt); end
    rst = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL reset_ptr got %b exp 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(2, 48'h0000_0000_00FF, 4);
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = '0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %b exp 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", out_valid); end
    n_vec++; if (out_data !== 48'h0000_0000_0FF0) begin n_err++; $display("FAIL single_data got %h exp 000000000ff0", out_data); end
    n_vec++; if (out_id !== 2'd2 || out_ovf !== 1'b0) begin n_err++; $display("FAIL single_id_ovf got %0d/%b exp 2/0", out_id, out_ovf); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 48'(i * 16 + 1), i + 1);
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_vec++; if (req_ready !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL rr_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_id !== 2'((c - 2) % 4) ||
            out_data !== ref_shift(48'(((c - 2) % 4) * 16 + 1), ((c - 2) % 4) + 1, 15)) begin
          n_err++;
          $display("FAIL rr_result c=%0d got v=%b id=%0d d=%h exp id=%0d", c, out_valid, out_id, out_data, (c - 2) % 4);
        end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_overflow();
    do_reset();
    set_req(0, 48'h8000_0000_0001, 1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 48'h0000_0000_0002) begin n_err++; $display("FAIL ovf_data got v=%b d=%h exp 1/000000000002", out_valid, out_data); end
    n_vec++; if (out_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", out_ovf); end
    tick();
    n_vec++; if (ovf_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_cnt_inc got %0d exp 1", ovf_cnt); end
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_ovf !== 1'b1 || ovf_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_second got v=%b o=%b cnt=%0d exp 1/1/1", out_valid, out_ovf, ovf_cnt); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_vec++; if (ovf_cnt !== 16'd0) begin n_err++; $display("FAIL ovf_clr_priority got %0d exp 0", ovf_cnt); end
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    do_reset();
    set_req(0, 48'h123, 2);
    set_req(1, 48'hABC, 3);
    out_ready = 1'b0;
    req_valid = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (|(req_valid & req_ready)) acc++;
      n_vec++;
      if (req_ready !== ((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL bp_ready c=%0d got %b", c, req_ready);
      end
      if (c >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 48'h48C || out_id !== 2'd0) begin
          n_err++; $display("FAIL bp_hold c=%0d got v=%b d=%h id=%0d exp 1/48c/0", c, out_valid, out_data, out_id);
        end
      end
      tick();
    end
    n_vec++; if (acc != 2) begin n_err++; $display("FAIL bp_accepts got %0d exp 2", acc); end
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 48'h48C) begin n_err++; $display("FAIL bp_rel0 got v=%b id=%0d d=%h", out_valid, out_id, out_data); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 48'h55E0) begin n_err++; $display("FAIL bp_rel1 got v=%b id=%0d d=%h", out_valid, out_id, out_data); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_boundary();
    do_reset();
    set_req(1, 48'hDEAD_BEEF_CAFE, 0);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    n_vec++; if (out_data !== 48'hDEAD_BEEF_CAFE || out_ovf !== 1'b0 || out_id !== 2'd1) begin n_err++; $display("FAIL shift0 got d=%h o=%b id=%0d", out_data, out_ovf, out_id); end
    tick();
    set_req(3, 48'h1, 15);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    n_vec++; if (out_data !== 48'h8000 || out_ovf !== 1'b0 || out_id !== 2'd3) begin n_err++; $display("FAIL shift15 got d=%h o=%b id=%0d", out_data, out_ovf, out_id); end
    tick();
  endtask

  task automatic test_clamp();
    do_reset();
    data2[0 +: W]  = 48'h0010_0000_0001;
    shift2[0 +: 4] = 4'd14;
    v2 = 2'b01;
    tick();
    v2 = '0;
    tick();
    n_vec++; if (ov2 !== 1'b1 || od2 !== 48'h1000) begin n_err++; $display("FAIL clamp_data got v=%b d=%h exp 1/1000", ov2, od2); end
    n_vec++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL clamp_ovf got %b exp 1", ovf2); end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(0, 48'h8000_0000_0001, 1);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    tick(); tick();
    n_vec++; if (ovf_cnt !== 16'd1) begin n_err++; $display("FAIL midrst_pre_cnt got %0d exp 1", ovf_cnt); end
    out_ready = 1'b0;
    set_req(1, 48'h5, 1);
    set_req(2, 48'h7, 1);
    req_valid = 4'b0110;
    tick(); tick();
    n_vec++; if (req_ready !== 4'b0000 || out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_full got r=%b v=%b exp 0000/1", req_ready, out_valid); end
    rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_ready got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0 || ovf_cnt !== 16'd0) begin n_err++; $display("FAIL midrst_clear got v=%b cnt=%0d exp 0/0", out_valid, ovf_cnt); end
    set_req(0, 48'h3, 2);
    req_valid = 4'b1111;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_ptr got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale got %b exp 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 48'hC) begin n_err++; $display("FAIL midrst_new got v=%b id=%0d d=%h exp 1/0/c", out_valid, out_id, out_data); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_drain got %b exp 0", out_valid); end
  endtask

  // Reference: a queue of in-flight items, the head optionally on the output.
  task automatic test_random();
    item_t       q[$];
    item_t       it;
    bit          head_out;
    int          ptr, cnt, g;
    bit          s1_occ, s2_adv, s1_adv, any;
    logic [NR-1:0] exp_ready;
    logic [W-1:0]  d_arr [NR];
    int            s_arr [NR];
    logic [63:0]   r;
    do_reset();
    head_out = 0; ptr = 0; cnt = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        r = {$urandom(), $urandom()};
        d_arr[i] = ($urandom_range(0, 1) == 1) ? r[W-1:0] : {16'h0, r[31:0]};
        s_arr[i] = $urandom_range(0, 15);
        set_req(i, d_arr[i], s_arr[i]);
      end
      req_valid = 4'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 31) == 0);

      s1_occ = (q.size() == 2) || (q.size() == 1 && !head_out);
      s2_adv = !head_out || out_ready;
      s1_adv = !s1_occ || s2_adv;
      any = 0; g = 0;
      for (int i = 0; i < NR; i++) begin
        if (!any && req_valid[(ptr + i) % NR]) begin any = 1; g = (ptr + i) % NR; end
      end
      exp_ready = (s1_adv && any) ? 4'(1 << g) : 4'b0000;

      #1;
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, req_ready, exp_ready); end
      n_vec++; if (out_valid !== head_out) begin n_err++; $display("FAIL rnd_valid cyc=%0d got %b exp %b", cyc, out_valid, head_out); end
      n_vec++; if (ovf_cnt !== 16'(cnt)) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got %0d exp %0d", cyc, ovf_cnt, cnt); end
      if (head_out) begin
        n_vec++;
        if (out_data !== ref_shift(q[0].d, q[0].s, 15) || out_id !== 2'(q[0].id) ||
            out_ovf !== ref_ovf(q[0].d, q[0].s, 15)) begin
          n_err++;
          $display("FAIL rnd_result cyc=%0d got d=%h id=%0d o=%b exp d=%h id=%0d o=%b", cyc,
                   out_data, out_id, out_ovf, ref_shift(q[0].d, q[0].s, 15), q[0].id,
                   ref_ovf(q[0].d, q[0].s, 15));
        end
      end

      if (head_out && out_ready) begin
        if (ref_ovf(q[0].d, q[0].s, 15) && cnt < 65535) cnt++;
        void'(q.pop_front());
        head_out = 0;
      end
      if (ovf_clr) cnt = 0;
      if (s2_adv && s1_occ) head_out = 1;
      if (s1_adv && any) begin
        it.d = d_arr[g]; it.s = s_arr[g]; it.id = g;
        q.push_back(it);
        ptr = (g + 1) % NR;
      end
      tick();
    end
    req_valid = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_boundary();
    test_clamp();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
